// File: rtl/fwd_history_unit.sv
// fwd_history_unit: DEPTH-entry in-flight write history with
// youngest-first operand forwarding and load-use stall detection.
module fwd_history_unit #(
  parameter int DATA_W      = 16,
  parameter int REG_W       = 4,
  parameter int DEPTH       = 3,
  parameter int ZERO_REG_EN = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       advance,
  input  logic                       wb_valid,
  input  logic                       wb_we1,
  input  logic [REG_W-1:0]           wb_dst1,
  input  logic [DATA_W-1:0]          wb_data1,
  input  logic                       wb_we2,
  input  logic [REG_W-1:0]           wb_dst2,
  input  logic [DATA_W-1:0]          wb_data2,
  input  logic                       wb_pending,
  input  logic                       ld_done,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic [REG_W-1:0]           rs1,
  input  logic [REG_W-1:0]           rs2,
  output logic                       fwdA,
  output logic                       fwdB,
  output logic [DATA_W-1:0]          fA,
  output logic [DATA_W-1:0]          fB,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] inflight
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic              we1;
    logic [REG_W-1:0]  dst1;
    logic [DATA_W-1:0] d1;
    logic              pend;
    logic              we2;
    logic [REG_W-1:0]  dst2;
    logic [DATA_W-1:0] d2;
  } ent_t;

  ent_t h   [DEPTH];
  ent_t nxt [DEPTH];

  logic fhit;
  int   ftgt;

  // oldest pending entry: last hit in an ascending scan
  always_comb begin
    fhit = 1'b0;
    ftgt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (h[i].valid && h[i].pend) begin
        fhit = 1'b1;
        ftgt = i;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      nxt[i] = h[i];
    if (advance) begin
      for (int i = DEPTH - 1; i > 0; i--)
        nxt[i] = h[i-1];
      nxt[0].valid = wb_valid;
      nxt[0].we1   = wb_we1;
      nxt[0].dst1  = wb_dst1;
      nxt[0].d1    = wb_data1;
      nxt[0].pend  = wb_pending & wb_we1;
      nxt[0].we2   = wb_we2;
      nxt[0].dst2  = wb_dst2;
      nxt[0].d2    = wb_data2;
    end
    // fill lands at the post-shift slot; dropped if it retires
    if (ld_done && fhit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((!advance && ftgt == i) ||
            (advance && i > 0 && ftgt == i - 1)) begin
          nxt[i].d1   = ld_data;
          nxt[i].pend = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        h[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++)
        h[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        h[i] <= nxt[i];
    end
  end

  // result: {fwd, stall, value}
  function automatic logic [DATA_W+1:0] look(
    input logic [REG_W-1:0] rs
  );
    logic [DATA_W+1:0] res;
    logic              done;
    res  = '0;
    done = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!done && h[i].valid) begin
        if (h[i].we1 && h[i].dst1 == rs) begin
          done = 1'b1;
          if (h[i].pend)
            res = {1'b0, 1'b1, {DATA_W{1'b0}}};
          else
            res = {1'b1, 1'b0, h[i].d1};
        end else if (h[i].we2 && h[i].dst2 == rs) begin
          done = 1'b1;
          res  = {1'b1, 1'b0, h[i].d2};
        end
      end
    end
    if (ZERO_REG_EN != 0 && rs == '0)
      res = '0;
    return res;
  endfunction

  logic [DATA_W+1:0] ra;
  logic [DATA_W+1:0] rb;

  always_comb begin
    ra = look(rs1);
    rb = look(rs2);
  end

  assign fwdA  = ra[DATA_W+1];
  assign fwdB  = rb[DATA_W+1];
  assign fA    = ra[DATA_W-1:0];
  assign fB    = rb[DATA_W-1:0];
  assign stall = ra[DATA_W] | rb[DATA_W];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < DEPTH; i++)
      inflight = inflight + CW'(h[i].valid);
  end

endmodule

// File: tb/tb_fwd_history_unit.sv
// tb_fwd_history_unit: scoreboard bench for fwd_history_unit
// (DEPTH=3, plus a ZERO_REG_EN=1 instance on shared inputs).
module tb_fwd_history_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, advance;
  logic        wb_valid, wb_we1, wb_we2, wb_pending;
  logic [3:0]  wb_dst1, wb_dst2;
  logic [15:0] wb_data1, wb_data2;
  logic        ld_done;
  logic [15:0] ld_data;
  logic [3:0]  rs1, rs2;
  logic        fwdA, fwdB, stall;
  logic [15:0] fA, fB;
  logic [1:0]  inflight;
  logic        zfwdA, zfwdB, zstall;
  logic [15:0] zfA, zfB;
  logic [1:0]  zinfl;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fwd_history_unit #(
    .DATA_W(16), .REG_W(4), .DEPTH(3), .ZERO_REG_EN(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .advance(advance),
    .wb_valid(wb_valid), .wb_we1(wb_we1), .wb_dst1(wb_dst1),
    .wb_data1(wb_data1), .wb_we2(wb_we2), .wb_dst2(wb_dst2),
    .wb_data2(wb_data2), .wb_pending(wb_pending),
    .ld_done(ld_done), .ld_data(ld_data),
    .rs1(rs1), .rs2(rs2),
    .fwdA(fwdA), .fwdB(fwdB), .fA(fA), .fB(fB),
    .stall(stall), .inflight(inflight)
  );

  fwd_history_unit #(
    .DATA_W(16), .REG_W(4), .DEPTH(3), .ZERO_REG_EN(1)
  ) u_zero (
    .clk(clk), .rst_n(rst_n), .flush(flush), .advance(advance),
    .wb_valid(wb_valid), .wb_we1(wb_we1), .wb_dst1(wb_dst1),
    .wb_data1(wb_data1), .wb_we2(wb_we2), .wb_dst2(wb_dst2),
    .wb_data2(wb_data2), .wb_pending(wb_pending),
    .ld_done(ld_done), .ld_data(ld_data),
    .rs1(rs1), .rs2(rs2),
    .fwdA(zfwdA), .fwdB(zfwdB), .fA(zfA), .fB(zfB),
    .stall(zstall), .inflight(zinfl)
  );

  typedef struct packed {
    logic        fa;
    logic [15:0] va;
    logic        fb;
    logic [15:0] vb;
    logic        st;
    logic [1:0]  inf;
  } exp_t;

  exp_t  expq [$];
  string tagq [$];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    advance    = 1'b0;
    flush      = 1'b0;
    ld_done    = 1'b0;
    wb_valid   = 1'b0;
    wb_we1     = 1'b0;
    wb_we2     = 1'b0;
    wb_pending = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(logic [3:0] d1, logic [15:0] v1,
                      logic we2, logic [3:0] d2,
                      logic [15:0] v2, logic pend);
    wb_valid   = 1'b1;
    wb_we1     = 1'b1;
    wb_dst1    = d1;
    wb_data1   = v1;
    wb_we2     = we2;
    wb_dst2    = d2;
    wb_data2   = v2;
    wb_pending = pend;
    advance    = 1'b1;
    tick();
  endtask

  task automatic bubble();
    advance = 1'b1;
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
  endtask

  task automatic obs(string tag, bit wait_edge,
                     logic [3:0] a, logic [3:0] b,
                     logic efa, logic [15:0] eva,
                     logic efb, logic [15:0] evb,
                     logic est, logic [1:0] einf);
    exp_t e;
    string t;
    rs1 = a;
    rs2 = b;
    expq.push_back('{efa, eva, efb, evb, est, einf});
    tagq.push_back(tag);
    if (wait_edge)
      @(negedge clk);
    else
      #1;
    e = expq.pop_front();
    t = tagq.pop_front();
    chk({t, ".fwdA"}, 32'(fwdA), 32'(e.fa));
    chk({t, ".fA"}, 32'(fA), 32'(e.va));
    chk({t, ".fwdB"}, 32'(fwdB), 32'(e.fb));
    chk({t, ".fB"}, 32'(fB), 32'(e.vb));
    chk({t, ".stall"}, 32'(stall), 32'(e.st));
    chk({t, ".inflight"}, 32'(inflight), 32'(e.inf));
  endtask

  initial begin
    rst_n    = 1'b0;
    idle();
    wb_dst1  = '0;
    wb_dst2  = '0;
    wb_data1 = '0;
    wb_data2 = '0;
    ld_data  = '0;
    rs1      = '0;
    rs2      = '0;
    #3;
    obs("reset", 1'b0, 4'd5, 4'd3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    push(4'd5, 16'h1111, 0, 0, 0, 0);
    push(4'd5, 16'h2222, 0, 0, 0, 0);
    obs("young", 1'b1, 4'd5, 4'd0, 1, 16'h2222, 0, 0, 0, 2);
    bubble();
    bubble();
    obs("young_e2", 1'b1, 4'd5, 4'd0, 1, 16'h2222, 0, 0, 0, 1);
    bubble();
    obs("young_gone", 1'b1, 4'd5, 4'd0, 0, 0, 0, 0, 0, 0);

    push(4'd1, 16'h0101, 0, 0, 0, 0);
    push(4'd2, 16'h0202, 0, 0, 0, 0);
    push(4'd3, 16'h0303, 0, 0, 0, 0);
    obs("fill3", 1'b1, 4'd1, 4'd2, 1, 16'h0101, 1, 16'h0202, 0, 3);
    #1 rst_n = 1'b0;
    obs("rst_mid", 1'b0, 4'd1, 4'd2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    push(4'd3, 16'hAAAA, 1, 4'd15, 16'h0007, 0);
    obs("dual", 1'b1, 4'd15, 4'd3, 1, 16'h0007, 1, 16'hAAAA, 0, 1);
    push(4'd4, 16'hAAAA, 1, 4'd4, 16'h0007, 0);
    obs("dual_s1", 1'b1, 4'd4, 4'd15, 1, 16'hAAAA, 1, 16'h0007, 0, 2);
    do_flush();

    push(4'd2, 16'hFFFF, 0, 0, 0, 1);
    obs("lu_stall", 1'b1, 4'd0, 4'd2, 0, 0, 0, 0, 1, 1);
    ld_done = 1'b1;
    ld_data = 16'hBEEF;
    tick();
    obs("lu_fill", 1'b1, 4'd0, 4'd2, 0, 0, 1, 16'hBEEF, 0, 1);
    do_flush();

    push(4'd9, 16'h9999, 0, 0, 0, 0);
    push(4'd9, 16'h0000, 0, 0, 0, 1);
    obs("lu_young", 1'b1, 4'd9, 4'd0, 0, 0, 0, 0, 1, 2);
    do_flush();

    push(4'd6, 16'h0000, 0, 0, 0, 1);
    push(4'd7, 16'h0000, 0, 0, 0, 1);
    obs("two_pend", 1'b1, 4'd6, 4'd7, 0, 0, 0, 0, 1, 2);
    ld_done = 1'b1;
    ld_data = 16'hCAFE;
    advance = 1'b1;
    tick();
    obs("fill_shift", 1'b1, 4'd6, 4'd7, 1, 16'hCAFE, 0, 0, 1, 2);
    ld_done = 1'b1;
    ld_data = 16'h1234;
    tick();
    ld_done = 1'b1;
    ld_data = 16'h5555;
    tick();
    obs("no_pend", 1'b1, 4'd6, 4'd7, 1, 16'hCAFE, 1, 16'h1234, 0, 2);
    do_flush();

    push(4'd2, 16'h0000, 0, 0, 0, 1);
    push(4'd3, 16'h3333, 0, 0, 0, 0);
    flush    = 1'b1;
    advance  = 1'b1;
    ld_done  = 1'b1;
    ld_data  = 16'h7777;
    wb_valid = 1'b1;
    wb_we1   = 1'b1;
    wb_dst1  = 4'd4;
    wb_data1 = 16'h4444;
    tick();
    obs("flush_pri", 1'b1, 4'd3, 4'd4, 0, 0, 0, 0, 0, 0);
    obs("flush_pend", 1'b1, 4'd2, 4'd2, 0, 0, 0, 0, 0, 0);

    push(4'd0, 16'h0ABC, 0, 0, 0, 0);
    obs("zero_off", 1'b1, 4'd0, 4'd1, 1, 16'h0ABC, 0, 0, 0, 1);
    chk("zero_on.fwdA", 32'(zfwdA), 32'd0);
    chk("zero_on.fA", 32'(zfA), 32'd0);
    chk("zero_on.inflight", 32'(zinfl), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
